// File: rtl/vector_data_mem_if.sv
// vector_data_mem_if: CPU vector port and VGA fetch port of the vector data memory
interface vector_data_mem_if #(
  parameter int N  = 8,
  parameter int L  = 6,
  parameter int AW = 17
);
  logic           cpu_req;
  logic           cpu_we;
  logic [AW-1:0]  cpu_addr;
  logic [L-1:0]   cpu_wmask;
  logic [L*N-1:0] cpu_wdata;
  logic           cpu_ready;
  logic           cpu_rvalid;
  logic [L*N-1:0] cpu_rdata;
  logic           vga_req;
  logic [AW-1:0]  vga_addr;
  logic           vga_gnt;
  logic           vga_rvalid;
  logic [L*N-1:0] vga_rdata;
  logic           addr_err;
  logic [15:0]    conflicts;
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wmask, cpu_wdata, vga_req, vga_addr,
    input  cpu_ready, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata, addr_err, conflicts
  );
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wmask, cpu_wdata, vga_req, vga_addr,
    output cpu_ready, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata, addr_err, conflicts
  );
endinterface

// File: rtl/vector_data_mem.sv
// vector_data_mem: L-lane vector RAM arbitrating a CPU port against a VGA fetch port
module vector_data_mem #(
  parameter int N       = 8,
  parameter int L       = 6,
  parameter int DEPTH   = 4096,
  parameter int AW      = 17,
  parameter int MAXWAIT = 4
) (
  input logic              clk,
  input logic              reset,
  vector_data_mem_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int SW = $clog2(MAXWAIT + 1);
  logic [L*N-1:0] mem [DEPTH];
  logic [SW-1:0]  starve;
  logic           cpu_gnt, vga_gnt, cpu_in, vga_in, acc_in;
  logic [IW-1:0]  acc_idx;
  logic [L*N-1:0] rd_word;
  // grants are gated by reset so nothing is acknowledged while held in reset
  always_comb begin
    cpu_gnt = reset && bus.cpu_req && (!bus.vga_req || starve == SW'(MAXWAIT));
    vga_gnt = reset && bus.vga_req && !cpu_gnt;
    cpu_in  = {1'b0, bus.cpu_addr} < (AW+1)'(DEPTH);
    vga_in  = {1'b0, bus.vga_addr} < (AW+1)'(DEPTH);
    acc_in  = cpu_gnt ? cpu_in : vga_in;
    acc_idx = cpu_gnt ? bus.cpu_addr[IW-1:0] : bus.vga_addr[IW-1:0];
    rd_word = acc_in ? mem[acc_idx] : '0;
  end
  assign bus.cpu_ready = cpu_gnt;
  assign bus.vga_gnt   = vga_gnt;
  always_ff @(posedge clk)
    if (cpu_gnt && bus.cpu_we && cpu_in)
      for (int i = 0; i < L; i++)
        if (bus.cpu_wmask[i]) mem[acc_idx][i*N +: N] <= bus.cpu_wdata[i*N +: N];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      starve         <= '0;
      bus.cpu_rvalid <= 1'b0;
      bus.vga_rvalid <= 1'b0;
      bus.cpu_rdata  <= '0;
      bus.vga_rdata  <= '0;
      bus.addr_err   <= 1'b0;
      bus.conflicts  <= '0;
    end else begin
      starve         <= (bus.cpu_req && !cpu_gnt) ? starve + 1'b1 : '0;
      bus.cpu_rvalid <= cpu_gnt && !bus.cpu_we;
      bus.vga_rvalid <= vga_gnt;
      if (cpu_gnt && !bus.cpu_we) bus.cpu_rdata <= rd_word;
      if (vga_gnt) bus.vga_rdata <= rd_word;
      if ((cpu_gnt && !cpu_in) || (vga_gnt && !vga_in)) bus.addr_err <= 1'b1;
      if (bus.cpu_req && bus.vga_req && bus.conflicts != '1) bus.conflicts <= bus.conflicts + 1'b1;
    end
endmodule
